// File: rtl/alsu_req_scheduler_pkg.sv
// Shared definitions for the ALSU request scheduler: op packing, opcodes,
// FSM states and the illegal-op check applied at issue.
package alsu_sched_pkg;

  localparam int OP_W       = 16;
  localparam int FIELD_W    = 3;
  localparam int A_LSB      = 13;
  localparam int B_LSB      = 10;
  localparam int OPC_LSB    = 7;
  localparam int CIN_BIT    = 6;
  localparam int SERIAL_BIT = 5;
  localparam int DIR_BIT    = 4;
  localparam int RED_A_BIT  = 3;
  localparam int RED_B_BIT  = 2;
  localparam int BYP_A_BIT  = 1;
  localparam int BYP_B_BIT  = 0;

  // All-zero op: the ALSU computes A&B = 0, which clears its out register.
  localparam logic [OP_W-1:0] IDLE_OP = '0;

  localparam logic [FIELD_W-1:0] OP_AND   = 3'b000;
  localparam logic [FIELD_W-1:0] OP_XOR   = 3'b001;
  localparam logic [FIELD_W-1:0] OP_ADD   = 3'b010;
  localparam logic [FIELD_W-1:0] OP_MULT  = 3'b011;
  localparam logic [FIELD_W-1:0] OP_SHIFT = 3'b100;
  localparam logic [FIELD_W-1:0] OP_ROT   = 3'b101;
  localparam logic [FIELD_W-1:0] OP_INV0  = 3'b110;
  localparam logic [FIELD_W-1:0] OP_INV1  = 3'b111;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } sched_state_e;

  function automatic logic [FIELD_W-1:0] op_opcode(input logic [OP_W-1:0] op);
    return op[OPC_LSB +: FIELD_W];
  endfunction

  // Reduction is only meaningful for AND/XOR; a bypass bit overrides everything.
  function automatic logic op_illegal(input logic [OP_W-1:0] op);
    logic [FIELD_W-1:0] opc;
    logic               red;
    logic               byp;
    opc = op_opcode(op);
    red = op[RED_A_BIT] | op[RED_B_BIT];
    byp = op[BYP_A_BIT] | op[BYP_B_BIT];
    if (opc == OP_INV0 || opc == OP_INV1) begin
      return 1'b1;
    end
    return red && !byp && (opc >= OP_ADD) && (opc <= OP_ROT);
  endfunction

endpackage

// File: rtl/alsu_req_scheduler_if.sv
// Requester, ALSU-pin and response bundle of the ALSU request scheduler.
// slave is the scheduler side, master the requester/ALSU environment side.
interface alsu_req_scheduler_if #(
  parameter int NUM_REQ = 2
) ();

  localparam int OP_W = alsu_sched_pkg::OP_W;
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ*OP_W-1:0] req_op;
  logic [NUM_REQ-1:0]      req_lock;

  logic [OP_W-1:0]         alsu_op;
  logic [5:0]              alsu_out;
  logic                    alsu_valid;

  logic                    rsp_valid;
  logic [ID_W-1:0]         rsp_id;
  logic [5:0]              rsp_data;
  logic                    rsp_err;
  logic [7:0]              err_count;
  logic                    locked;

  modport slave (
    input  req_valid, req_op, req_lock, alsu_out, alsu_valid,
    output req_ready, alsu_op, rsp_valid, rsp_id, rsp_data, rsp_err,
           err_count, locked
  );

  modport master (
    output req_valid, req_op, req_lock, alsu_out, alsu_valid,
    input  req_ready, alsu_op, rsp_valid, rsp_id, rsp_data, rsp_err,
           err_count, locked
  );

endinterface

// File: rtl/alsu_req_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first set request
// found when searching upward (with wrap) from ptr.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant
);

  logic [NUM_REQ-1:0] req_rot;
  logic [NUM_REQ-1:0] grant_rot;
  logic               seen;

  // Rotate so that ptr sits at bit 0, pick the lowest set bit, rotate back.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
    assign req_rot[gi] = req[ID_W'((int'(ptr) + gi) % NUM_REQ)];
    assign grant[gi]   = grant_rot[ID_W'((gi + NUM_REQ - int'(ptr)) % NUM_REQ)];
  end

  always_comb begin
    seen      = 1'b0;
    grant_rot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_rot[i] = req_rot[i] & ~seen;
      seen         = seen | req_rot[i];
    end
  end

endmodule

// File: rtl/alsu_req_scheduler.sv
// Round-robin front end for the ALSU: arbitrates requesters (with lock for
// dependent shift/rotate chains), registers the op onto the ALSU pins and
// routes the ALSU result back tagged with requester id and error flag.
module alsu_req_scheduler
  import alsu_sched_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int LOCK_TIMEOUT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  alsu_req_scheduler_if.slave  bus
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [3:0] IDLE_LIMIT = 4'(LOCK_TIMEOUT - 1);

  typedef struct packed {
    logic            v;
    logic [ID_W-1:0] id;
    logic            ill;
  } tag_t;

  sched_state_e    state_reg, state_next;
  logic [ID_W-1:0] ptr_reg, ptr_next;
  logic [ID_W-1:0] owner_reg, owner_next;
  logic [3:0]      idle_cnt_reg, idle_cnt_next;

  logic [OP_W-1:0] alsu_op_reg;
  tag_t            issue_tag_reg;
  tag_t            rsp_tag_reg;
  logic [7:0]      err_count_reg;

  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] owner_onehot;
  logic [NUM_REQ-1:0] ready;
  logic [ID_W-1:0]    grant_id;
  logic [ID_W-1:0]    sel_id;
  logic [OP_W-1:0]    op_arr [NUM_REQ];
  logic [OP_W-1:0]    sel_op;
  logic               sel_lock;
  logic               hs;
  logic               lock_timeout;
  logic               rsp_err_w;

  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] id);
    if (int'(id) == NUM_REQ - 1) begin
      return '0;
    end
    return id + 1'b1;
  endfunction

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req   (bus.req_valid),
    .ptr   (ptr_reg),
    .grant (grant)
  );

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign owner_onehot[gi] = (owner_reg == ID_W'(gi));
    assign op_arr[gi]       = bus.req_op[gi*OP_W +: OP_W];
  end

  always_comb begin
    grant_id = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        grant_id = ID_W'(i);
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ARB;
      ptr_reg      <= '0;
      owner_reg    <= '0;
      idle_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      owner_reg    <= owner_next;
      idle_cnt_reg <= idle_cnt_next;
    end
  end

  // Output / selection logic: ready is held low while reset is asserted.
  always_comb begin
    ready  = '0;
    sel_id = (state_reg == ARB) ? grant_id : owner_reg;
    if (!rst) begin
      ready = (state_reg == ARB) ? grant : owner_onehot;
    end
  end

  assign hs           = |(ready & bus.req_valid);
  assign sel_op       = op_arr[sel_id];
  assign sel_lock     = bus.req_lock[sel_id];
  assign lock_timeout = (state_reg == LOCKED) && !bus.req_valid[owner_reg] &&
                        (idle_cnt_reg == IDLE_LIMIT);

  // Next-state logic
  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    owner_next    = owner_reg;
    idle_cnt_next = idle_cnt_reg;
    case (state_reg)
      ARB: begin
        idle_cnt_next = '0;
        if (hs) begin
          ptr_next = next_ptr(sel_id);
          if (sel_lock) begin
            state_next = LOCKED;
            owner_next = sel_id;
          end
        end
      end
      LOCKED: begin
        if (hs) begin
          idle_cnt_next = '0;
          if (!sel_lock) begin
            state_next = ARB;
            ptr_next   = next_ptr(owner_reg);
          end
        end else if (lock_timeout) begin
          state_next    = ARB;
          ptr_next      = next_ptr(owner_reg);
          idle_cnt_next = '0;
        end else begin
          idle_cnt_next = idle_cnt_reg + 4'd1;
        end
      end
      default: state_next = ARB;
    endcase
  end

  // Issue register plus two tag stages: the second lines up with the
  // cycle in which the ALSU presents the registered result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alsu_op_reg   <= IDLE_OP;
      issue_tag_reg <= '0;
      rsp_tag_reg   <= '0;
      err_count_reg <= '0;
    end else begin
      alsu_op_reg       <= hs ? sel_op : IDLE_OP;
      issue_tag_reg.v   <= hs;
      issue_tag_reg.id  <= sel_id;
      issue_tag_reg.ill <= hs & op_illegal(sel_op);
      rsp_tag_reg       <= issue_tag_reg;
      if (rsp_err_w && err_count_reg != 8'hFF) begin
        err_count_reg <= err_count_reg + 8'd1;
      end
    end
  end

  assign rsp_err_w = rsp_tag_reg.v & (rsp_tag_reg.ill | ~bus.alsu_valid);

  assign bus.req_ready = ready;
  assign bus.alsu_op   = alsu_op_reg;
  assign bus.rsp_valid = rsp_tag_reg.v;
  assign bus.rsp_id    = rsp_tag_reg.v ? rsp_tag_reg.id : '0;
  assign bus.rsp_data  = bus.alsu_out;
  assign bus.rsp_err   = rsp_err_w;
  assign bus.err_count = err_count_reg;
  assign bus.locked    = (state_reg == LOCKED);

endmodule

// File: tb/tb_alsu_req_scheduler.sv
// Directed bench for alsu_req_scheduler with a small behavioural ALSU and a
// response scoreboard checked by an independent monitor.
module tb_alsu_req_scheduler;
  import alsu_sched_pkg::*;

  localparam int NUM_REQ      = 2;
  localparam int LOCK_TIMEOUT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alsu_req_scheduler_if #(.NUM_REQ(NUM_REQ)) bus ();

  alsu_req_scheduler #(
    .NUM_REQ      (NUM_REQ),
    .LOCK_TIMEOUT (LOCK_TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural ALSU: bypass, AND/XOR/ADD/MULT, shift/rotate of its own out;
  // opcodes 11x give out=0 with valid low.
  logic [5:0] alsu_out_r;
  logic       alsu_valid_r;
  logic [2:0] m_a, m_b, m_opc;
  logic       m_cin, m_sin, m_dir, m_bpa, m_bpb;
  assign m_a   = bus.alsu_op[15:13];
  assign m_b   = bus.alsu_op[12:10];
  assign m_opc = bus.alsu_op[9:7];
  assign m_cin = bus.alsu_op[6];
  assign m_sin = bus.alsu_op[5];
  assign m_dir = bus.alsu_op[4];
  assign m_bpa = bus.alsu_op[1];
  assign m_bpb = bus.alsu_op[0];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      alsu_out_r   <= 6'd0;
      alsu_valid_r <= 1'b0;
    end else begin
      alsu_valid_r <= 1'b1;
      if (m_bpa) alsu_out_r <= {3'b000, m_a};
      else if (m_bpb) alsu_out_r <= {3'b000, m_b};
      else begin
        case (m_opc)
          3'b000: alsu_out_r <= {3'b000, m_a & m_b};
          3'b001: alsu_out_r <= {3'b000, m_a ^ m_b};
          3'b010: alsu_out_r <= 6'(m_a) + 6'(m_b) + 6'(m_cin);
          3'b011: alsu_out_r <= 6'(m_a) * 6'(m_b);
          3'b100: alsu_out_r <= m_dir ? {alsu_out_r[4:0], m_sin} : {m_sin, alsu_out_r[5:1]};
          3'b101: alsu_out_r <= m_dir ? {alsu_out_r[4:0], alsu_out_r[5]} : {alsu_out_r[0], alsu_out_r[5:1]};
          default: begin
            alsu_out_r   <= 6'd0;
            alsu_valid_r <= 1'b0;
          end
        endcase
      end
    end
  end
  assign bus.alsu_out   = alsu_out_r;
  assign bus.alsu_valid = alsu_valid_r;

  typedef struct packed {
    logic [1:0] id;
    logic [5:0] data;
    logic       err;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t mon_exp;
  rsp_t mon_got;
  int   checks = 0;
  int   errors = 0;

  always @(negedge clk) begin
    if (bus.rsp_valid === 1'b1) begin
      mon_got = {2'(bus.rsp_id), bus.rsp_data, bus.rsp_err};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got id=%0d data=%0d err=%0d, required no response",
                 mon_got.id, mon_got.data, mon_got.err);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL rsp: got id=%0d data=%0d err=%0d, required id=%0d data=%0d err=%0d",
                   mon_got.id, mon_got.data, mon_got.err, mon_exp.id, mon_exp.data, mon_exp.err);
        end else begin
          $display("rsp id=%0d data=%0d err=%0d ok", mon_got.id, mon_got.data, mon_got.err);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, req);
    end
  endtask

  task automatic expect_rsp(input int id, input int data, input int err);
    exp_q.push_back({2'(id), 6'(data), 1'(err)});
  endtask

  function automatic logic [15:0] mk_op(input logic [2:0] a, input logic [2:0] b,
                                        input logic [2:0] opc, input logic cin,
                                        input logic sin, input logic dir,
                                        input logic ra, input logic rb,
                                        input logic bpa, input logic bpb);
    return {a, b, opc, cin, sin, dir, ra, rb, bpa, bpb};
  endfunction

  logic [15:0] lk_op   [4];
  logic        lk_lock [4];
  int          lk_data [4];
  logic [15:0] add_op;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_lock  = '0;
    #1;
    bus.req_valid = 2'b11;
    @(negedge clk);
    check("rst_ready", 32'(bus.req_ready), 0);
    check("rst_alsu_op", 32'(bus.alsu_op), 0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    check("rst_rsp_id", 32'(bus.rsp_id), 0);
    check("rst_rsp_err", 32'(bus.rsp_err), 0);
    check("rst_err_count", 32'(bus.err_count), 0);
    check("rst_locked", 32'(bus.locked), 0);
    tick();
    tick();
    rst           = 1'b0;
    bus.req_valid = '0;
    tick();

    // Fairness: both valid, grants alternate starting at req0
    bus.req_op    = {mk_op(7, 7, OP_AND, 0, 0, 0, 0, 0, 0, 0), mk_op(7, 7, OP_AND, 0, 0, 0, 0, 0, 0, 0)};
    bus.req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      expect_rsp(i % 2, 7, 0);
      @(negedge clk);
      check("fair_ready", 32'(bus.req_ready), (i % 2 == 1) ? 2 : 1);
      tick();
    end
    bus.req_valid = '0;
    repeat (3) tick();

    // Add with latency checks: 3+5+1 = 9
    add_op            = mk_op(3, 5, OP_ADD, 1, 0, 0, 0, 0, 0, 0);
    bus.req_op[15:0]  = add_op;
    bus.req_valid     = 2'b01;
    expect_rsp(0, 9, 0);
    @(negedge clk);
    check("add_ready", 32'(bus.req_ready), 1);
    tick();
    bus.req_valid = '0;
    @(negedge clk);
    check("add_alsu_op", 32'(bus.alsu_op), 32'(add_op));
    check("add_no_early_rsp", 32'(bus.rsp_valid), 0);
    tick();
    @(negedge clk);
    check("add_rsp_valid", 32'(bus.rsp_valid), 1);
    repeat (3) tick();

    // Lock and shift chain on req1 while req0 waits
    lk_op[0] = mk_op(7, 0, OP_AND, 0, 0, 0, 0, 0, 1, 0);
    lk_op[1] = mk_op(0, 0, OP_SHIFT, 0, 1, 1, 0, 0, 0, 0);
    lk_op[2] = mk_op(0, 0, OP_SHIFT, 0, 1, 1, 0, 0, 0, 0);
    lk_op[3] = mk_op(0, 0, OP_SHIFT, 0, 1, 1, 0, 0, 0, 0);
    lk_lock  = '{1'b1, 1'b1, 1'b1, 1'b0};
    lk_data  = '{7, 15, 31, 63};
    bus.req_op[15:0] = mk_op(1, 1, OP_AND, 0, 0, 0, 0, 0, 0, 0);
    bus.req_valid    = 2'b11;
    for (int i = 0; i < 4; i++) begin
      bus.req_op[31:16] = lk_op[i];
      bus.req_lock      = {lk_lock[i], 1'b0};
      expect_rsp(1, lk_data[i], 0);
      @(negedge clk);
      check("lock_ready", 32'(bus.req_ready), 2);
      check("lock_state", 32'(bus.locked), (i > 0) ? 1 : 0);
      tick();
    end
    bus.req_lock = '0;
    expect_rsp(0, 1, 0);
    @(negedge clk);
    check("unlock_state", 32'(bus.locked), 0);
    check("unlock_ready", 32'(bus.req_ready), 1);
    tick();
    bus.req_valid = '0;
    repeat (3) tick();

    // Lock timeout: req1 locks then goes idle while req0 waits
    bus.req_op[31:16] = mk_op(2, 3, OP_AND, 0, 0, 0, 0, 0, 0, 0);
    bus.req_op[15:0]  = mk_op(5, 4, OP_AND, 0, 0, 0, 0, 0, 0, 0);
    bus.req_lock      = 2'b10;
    bus.req_valid     = 2'b10;
    expect_rsp(1, 2, 0);
    @(negedge clk);
    check("to_lock_ready", 32'(bus.req_ready), 2);
    tick();
    bus.req_valid = 2'b01;
    bus.req_lock  = '0;
    for (int i = 0; i < LOCK_TIMEOUT; i++) begin
      @(negedge clk);
      check("to_locked", 32'(bus.locked), 1);
      check("to_ready_held", 32'(bus.req_ready), 2);
      tick();
    end
    expect_rsp(0, 4, 0);
    @(negedge clk);
    check("to_released", 32'(bus.locked), 0);
    check("to_req0_ready", 32'(bus.req_ready), 1);
    tick();
    bus.req_valid = '0;
    repeat (3) tick();

    // Illegal ops
    @(negedge clk);
    check("err_count_0", 32'(bus.err_count), 0);
    bus.req_op[15:0] = mk_op(3, 2, OP_INV0, 0, 0, 0, 0, 0, 0, 0);
    bus.req_valid    = 2'b01;
    expect_rsp(0, 0, 1);
    tick();
    bus.req_valid = '0;
    repeat (3) tick();
    @(negedge clk);
    check("err_count_1", 32'(bus.err_count), 1);
    bus.req_op[15:0] = mk_op(1, 2, OP_ADD, 0, 0, 0, 1, 0, 0, 0);
    bus.req_valid    = 2'b01;
    expect_rsp(0, 3, 1);
    tick();
    bus.req_valid = '0;
    repeat (3) tick();
    @(negedge clk);
    check("err_count_2", 32'(bus.err_count), 2);

    // Reset one cycle after a handshake: no response, ptr back to req0
    bus.req_op[31:16] = mk_op(7, 7, OP_AND, 0, 0, 0, 0, 0, 0, 0);
    bus.req_valid     = 2'b10;
    tick();
    rst           = 1'b1;
    bus.req_valid = 2'b11;
    @(negedge clk);
    check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 0);
    check("mid_rst_alsu_op", 32'(bus.alsu_op), 0);
    check("mid_rst_ready", 32'(bus.req_ready), 0);
    check("mid_rst_err_count", 32'(bus.err_count), 0);
    check("mid_rst_locked", 32'(bus.locked), 0);
    tick();
    @(negedge clk);
    check("mid_rst_rsp_valid2", 32'(bus.rsp_valid), 0);
    tick();
    rst              = 1'b0;
    bus.req_op[15:0] = mk_op(6, 3, OP_AND, 0, 0, 0, 0, 0, 0, 0);
    expect_rsp(0, 2, 0);
    @(negedge clk);
    check("post_rst_ready", 32'(bus.req_ready), 1);
    tick();
    bus.req_valid = '0;
    repeat (4) tick();

    check("queue_drained", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alsu_req_scheduler.md
# alsu_req_scheduler

Multi-requester front end for the ALSU datapath. It arbitrates round-robin between NUM_REQ requesters and registers the winning operation onto the ALSU input pins. It routes the registered ALSU result back to the issuing requester, tagged with its ID and an error flag. A lock mechanism lets one requester issue back-to-back shift/rotate sequences that depend on the ALSU's previous `out`.

## Interface
- NUM_REQ, 2, number of requesters (2..4)
- LOCK_TIMEOUT, 4, idle cycles after which a held lock is force-released (1..15)
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- req_valid  in  NUM_REQ  per-requester operation valid
- req_ready  out  NUM_REQ  per-requester accept; handshake when valid & ready at posedge
- req_op  in  NUM_REQ×16  packed op per requester: {A[2:0], B[2:0], opcode[2:0], cin, serial_in, direction, red_op_A, red_op_B, byPass_A, byPass_B}
- req_lock  in  NUM_REQ  keep grant after this op
- alsu_op  out  16  registered op to ALSU pins, same packing
- alsu_out  in  6  ALSU registered result
- alsu_valid  in  1  ALSU registered valid
- rsp_valid  out  1  response strobe, one cycle
- rsp_id  out  $clog2(NUM_REQ)  requester that issued the op
- rsp_data  out  6  equals alsu_out in the response cycle
- rsp_err  out  1  ~alsu_valid OR locally detected illegal op
- err_count  out  8  saturating count of rsp_err responses
- locked  out  1  lock currently held

## Operation
- FSM states: ARB and LOCKED.
- ARB:
  - req_ready is one-hot to the round-robin winner among the valid requesters, searched from pointer ptr.
  - On handshake, ptr = winner+1 (mod NUM_REQ).
  - If the winner's req_lock=1, go to LOCKED with owner = winner.
- LOCKED:
  - Only the owner's req_ready=1.
  - A handshake with req_lock=0 releases: go to ARB, ptr = owner+1.
  - Each cycle the owner has req_valid=0, idle_cnt increments; any handshake clears it.
  - idle_cnt reaching LOCK_TIMEOUT forces ARB. The lock is released and no op is issued that cycle.
- Issue:
  - On handshake, alsu_op <= the selected req_op.
  - With no handshake, alsu_op <= IDLE_OP (all zero). The ALSU then computes A&B = 0, so `out` is cleared.
  - Shift/rotate therefore see the previous op's result only if issued on the very next cycle.
- Local illegal detection, flagged at issue and carried in the pipeline. An op is illegal when:
  - opcode is 110 or 111, or
  - red_op_A or red_op_B is set with opcode 010–101 and neither bypass bit is set.
- Response pipeline:
  - Tag stage {v, id, illegal} advances every cycle alongside alsu_op.
  - rsp_* are driven combinationally from the tag stage and alsu_out/alsu_valid.
- err_count increments on each rsp_valid&rsp_err and saturates at 255.

## Timing
- Reset values:
  - req_ready=0 during rst.
  - alsu_op=0, rsp_valid=0, rsp_id=0, rsp_err=0, err_count=0, locked=0, ptr=0, FSM=ARB.
- Latency:
  - Handshake at edge k → alsu_op valid after k.
  - ALSU registers the result at k+1.
  - rsp_valid high for the cycle between edges k+1 and k+2.
- Throughput: one op per cycle, fully pipelined. There is no response backpressure; requesters must sink responses.
- Simultaneous events:
  - In ARB, all-valid requesters resolve by ptr.
  - A lock request and a timeout in the same cycle: the handshake wins and idle_cnt clears.
- Reset mid-operation clears the tag stage; in-flight ops produce no response.
- req_ready is combinational from state and req_valid. req_op is sampled only at a handshake.

## Structure
- Package alsu_sched_pkg:
  - op field offsets/width (OP_W=16)
  - IDLE_OP constant
  - opcode constants (OP_AND..OP_ROT, OP_INV0/1)
  - state enum {ARB, LOCKED}
  - illegal-op function
- Sub-module rr_arbiter: NUM_REQ request vector plus ptr in, one-hot grant out, purely combinational.
- Top level holds the FSM, idle counter, issue register, tag stage and error counter.

## Test plan
- Add: req0 A=3, B=5, opcode=010, cin=1 → two edges later rsp_valid=1, rsp_id=0, rsp_data=9, rsp_err=0.
- Fairness: req0 and req1 continuously valid with opcode=000, A=B=7 → grants alternate 0,1,0,1; rsp_id follows the same order; each rsp_data=7.
- Lock and shift:
  - Stimulus: req1 issues byPass_A with A=7, then shift (opcode=100, direction=1, serial_in=1) twice back-to-back, all with req_lock=1, then a final op with req_lock=0.
  - Required: rsp_data 7, 15, 31; req_ready[0]=0 throughout the lock.
- Lock timeout: req1 locks, then drops valid while req0 is valid → after 4 idle cycles locked=0 and req0 is granted the next cycle.
- Illegal ops:
  - opcode=110 → rsp_err=1, rsp_data=0, err_count 0→1.
  - opcode=010 with red_op_A=1 → rsp_err=1; err_count increments to 2.
- Reset mid-flight: assert rst the cycle after a handshake → no rsp_valid; all outputs at reset values; the first post-reset grant goes to req0.
